// File: rtl/gemm_pack_pipe.sv
// Two-stage exponent-resolve and pack pipeline with tile/last tracking.
// Define GEMM_PACK_SAT_EN to saturate overflow to max finite instead of inf.
module gemm_pack_pipe #(
  parameter int expWidth = 4,
  parameter int sigWidth = 4,
  parameter int TILE_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [sigWidth-1:0]          in_mant,
  input  logic [expWidth-1:0]          in_expoff,
  input  logic [expWidth-1:0]          in_exp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [expWidth+sigWidth-1:0] out_data,
  output logic                         out_last,
  input  logic                         clr,
  output logic                         ovf_sticky,
  output logic                         unf_sticky
);

  localparam int EW = expWidth + 2;
  localparam int DW = expWidth + sigWidth;
  localparam int CW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(TILE_LEN - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << expWidth) - 1);

  logic                s1_valid;
  logic                s1_sign;
  logic [sigWidth-1:0] s1_mant;
  logic [EW-1:0]       s1_e;

  logic          s2_valid;
  logic          s2_ovf;
  logic          s2_unf;
  logic [DW-1:0] s2_data;

  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          unf_q;

  logic          s2_load;
  logic          s1_load;
  logic          xfer;
  logic [EW-1:0] e_next;
  logic          is_zero;
  logic          is_unf;
  logic          is_ovf;
  logic [DW-1:0] pack;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign xfer     = s2_valid && out_ready;

  // Two's-complement add in EW bits; no wrap for any input pair.
  assign e_next = {2'b00, in_exp}
                + {{2{in_expoff[expWidth-1]}}, in_expoff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mant  <= '0;
      s1_e     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_mant  <= in_mant;
      s1_e     <= e_next;
    end
  end

  assign is_zero = (s1_mant == '0);
  assign is_unf  = !is_zero &&
                   (s1_e[EW-1] || (s1_e == '0));
  assign is_ovf  = !is_zero && !s1_e[EW-1] &&
                   (s1_e >= EMAX);

  always_comb begin
    pack = {s1_sign, s1_e[expWidth-1:0],
            s1_mant[sigWidth-2:0]};
    unique case (1'b1)
      is_zero: pack = '0;
      is_unf:  pack = {s1_sign, {(DW-1){1'b0}}};
      is_ovf: begin
`ifdef GEMM_PACK_SAT_EN
        pack = {s1_sign, {(expWidth-1){1'b1}}, 1'b0,
                {(sigWidth-1){1'b1}}};
`else
        pack = {s1_sign, {expWidth{1'b1}},
                {(sigWidth-1){1'b0}}};
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      s2_data  <= s1_valid ? pack : '0;
      s2_ovf   <= s1_valid && is_ovf;
      s2_unf   <= s1_valid && is_unf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (xfer)
        cnt <= (clr || cnt == LAST) ? '0 : cnt + CW'(1);
      else if (clr)
        cnt <= '0;
      if (xfer && s2_ovf)
        ovf_q <= 1'b1;
      else if (clr)
        ovf_q <= 1'b0;
      if (xfer && s2_unf)
        unf_q <= 1'b1;
      else if (clr)
        unf_q <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_data   = s2_data;
  assign out_last   = s2_valid && (cnt == LAST);
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;

endmodule

// File: tb/tb_gemm_pack_pipe.sv
// Self-checking bench for gemm_pack_pipe with a queue-based reference model.
// Honors GEMM_PACK_SAT_EN for the expected overflow encoding.
module tb_gemm_pack_pipe;

  localparam int EW = 4;
  localparam int SW = 4;
  localparam int TL = 16;
  localparam int DW = EW + SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sign = 1'b0;
  logic [SW-1:0] in_mant = '0;
  logic [EW-1:0] in_expoff = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_ready = 1'b0;
  logic          clr = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic          ovf_sticky;
  logic          unf_sticky;
  logic [DW-1:0] out_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            ovf;
    bit            unf;
  } exp_t;

  exp_t q[$];
  int   m_cnt;
  bit   m_ovf;
  bit   m_unf;

`ifdef GEMM_PACK_SAT_EN
  localparam logic [DW-1:0] OVF_POS = 8'h77;
`else
  localparam logic [DW-1:0] OVF_POS = 8'h78;
`endif

  gemm_pack_pipe #(
    .expWidth(EW), .sigWidth(SW), .TILE_LEN(TL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mant(in_mant),
    .in_expoff(in_expoff), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .clr(clr), .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic exp_t ref_pack(bit s, int mant, int ex, int off);
    exp_t r;
    int   e;
    int   emax;
    int   sb;
    emax = (1 << EW) - 1;
    sb = int'(s) << (DW - 1);
    r.ovf = 0;
    r.unf = 0;
    if (off >= (1 << (EW - 1))) off -= (1 << EW);
    e = ex + off;
    if (mant == 0) r.data = '0;
    else if (e <= 0) begin
      r.data = DW'(sb);
      r.unf = 1;
    end else if (e >= emax) begin
      r.ovf = 1;
`ifdef GEMM_PACK_SAT_EN
      r.data = DW'(sb + ((emax - 1) << (SW - 1))
                   + ((1 << (SW - 1)) - 1));
`else
      r.data = DW'(sb + (emax << (SW - 1)));
`endif
    end else
      r.data = DW'(sb + (e << (SW - 1))
                   + (mant % (1 << (SW - 1))));
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_cnt = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic send1(bit s, logic [SW-1:0] m,
                       logic [EW-1:0] ex, logic [EW-1:0] off);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign = s;
    in_mant = m;
    in_exp = ex;
    in_expoff = off;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, ovf_sticky, unf_sticky} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0",
               {out_valid, out_last, out_data, ovf_sticky, unf_sticky});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_directed();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign = 1'b0;
    in_mant = 4'b1010;
    in_exp = 4'd7;
    in_expoff = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=%b exp=0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h32) begin
      failures++;
      $display("FAIL norm_data got=%b/%h exp=1/32", out_valid, out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b0 || unf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL norm_sticky got=%b%b exp=00", ovf_sticky, unf_sticky);
    end
    send1(1'b0, 4'b1100, 4'd14, 4'd2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== OVF_POS) begin
      failures++;
      $display("FAIL ovf_data got=%h exp=%h", out_data, OVF_POS);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky_set got=%b exp=1", ovf_sticky);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky_clr got=%b exp=0", ovf_sticky);
    end
    send1(1'b1, 4'b1000, 4'd1, 4'hD);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h80) begin
      failures++;
      $display("FAIL unf_data got=%h exp=80", out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (unf_sticky !== 1'b1 || ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL unf_sticky got=%b%b exp=01", ovf_sticky, unf_sticky);
    end
    send1(1'b1, 4'b0000, 4'd9, 4'd1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL zero_data got=%h exp=00", out_data);
    end
  endtask

  task automatic test_back_to_back();
    bit s_a[6];
    int m_a[6];
    int e_a[6];
    int o_a[6];
    int sent;
    int got;
    exp_t x;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_a[i] = 1'($urandom_range(1));
      m_a[i] = $urandom_range(8, 15);
      e_a[i] = $urandom_range(3, 10);
      o_a[i] = $urandom_range(0, 3);
    end
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_sign = s_a[sent];
        in_mant = SW'(m_a[sent]);
        in_exp = EW'(e_a[sent]);
        in_expoff = EW'(o_a[sent]);
      end
      #1;
      if (c >= 2 && c <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          failures++;
          $display("FAIL b2b_stall c=%0d got=%b/%0d exp=0/2",
                   c, in_ready, sent);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra got=%h exp=none", out_data);
        end else begin
          x = q.pop_front();
          if (out_data !== x.data) begin
            failures++;
            $display("FAIL b2b_data n=%0d got=%h exp=%h", got, out_data, x.data);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_pack(s_a[sent], m_a[sent], e_a[sent], o_a[sent]));
        sent++;
      end
    end
    checks++;
    if (got != 6 || q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d/%0d exp=6/0", got, q.size());
    end
  endtask

  task automatic test_random();
    exp_t x;
    bit   hold_v;
    logic [DW-1:0] hold_d;
    bit   s;
    int   m;
    int   ex;
    int   off;
    bit   xf;
    bit   set_o;
    bit   set_u;
    do_reset();
    hold_v = 0;
    hold_d = '0;
    for (int c = 0; c < 3000 && (c < 600 || q.size() > 0); c++) begin
      @(negedge clk);
      s = 1'($urandom_range(1));
      m = ($urandom_range(9) == 0) ? 0 : $urandom_range(15);
      ex = $urandom_range(15);
      off = $urandom_range(15);
      in_valid = (c < 600) && ($urandom_range(99) < 70);
      in_sign = s;
      in_mant = SW'(m);
      in_exp = EW'(ex);
      in_expoff = EW'(off);
      out_ready = ($urandom_range(99) < 60);
      clr = ($urandom_range(99) < 4);
      #1;
      checks++;
      if (ovf_sticky !== m_ovf || unf_sticky !== m_unf) begin
        failures++;
        $display("FAIL rnd_sticky c=%0d got=%b%b exp=%b%b",
                 c, ovf_sticky, unf_sticky, m_ovf, m_unf);
      end
      if (hold_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d) begin
          failures++;
          $display("FAIL rnd_hold c=%0d got=%b/%h exp=1/%h",
                   c, out_valid, out_data, hold_d);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      xf = out_valid && out_ready;
      set_o = 0;
      set_u = 0;
      if (xf) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra got=%h exp=none", out_data);
        end else begin
          x = q.pop_front();
          set_o = x.ovf;
          set_u = x.unf;
          if (out_data !== x.data || out_last !== (m_cnt == TL - 1)) begin
            failures++;
            $display("FAIL rnd_data c=%0d got=%h/%b exp=%h/%b", c,
                     out_data, out_last, x.data, (m_cnt == TL - 1));
          end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_pack(s, m, ex, off));
      if (xf) m_cnt = (clr || m_cnt == TL - 1) ? 0 : m_cnt + 1;
      else if (clr) m_cnt = 0;
      m_ovf = set_o ? 1 : (clr ? 0 : m_ovf);
      m_unf = set_u ? 1 : (clr ? 0 : m_unf);
    end
    clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_tile();
    int n;
    int k;
    do_reset();
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 32; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sign = 1'($urandom_range(1));
      in_mant = SW'($urandom_range(8, 15));
      in_exp = EW'($urandom_range(15));
      in_expoff = EW'($urandom_range(15));
      #1;
      if (out_valid) begin
        checks++;
        if (out_last !== (n % TL == TL - 1)) begin
          failures++;
          $display("FAIL tile_last n=%0d got=%b exp=%b",
                   n + 1, out_last, (n % TL == TL - 1));
        end
        n++;
      end
    end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL tile_count got=%0d exp=32", n);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL rst_mid got=%b%b/%h exp=00/00",
               out_valid, out_last, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    k = 0;
    for (int c = 0; c < 200 && n < 40; c++) begin
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b1;
      in_mant = SW'($urandom_range(8, 15));
      #1;
      if (out_valid) begin
        checks++;
        if (out_last !== (k == TL - 1)) begin
          failures++;
          $display("FAIL restart_last n=%0d got=%b exp=%b",
                   n, out_last, (k == TL - 1));
        end
        clr = (n == 20);
        k = (clr || k == TL - 1) ? 0 : k + 1;
        n++;
      end
    end
    clr = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_tile();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
